ef_pwm_deadtime: RTL and testbench

//  Downstream stage of the PWM32 generator: turns one PWM channel (pwmA or pwmB) into a

---
 rtl/ef_pwm_deadtime.sv | 160 ++++++++++++++++
 tb/tb_ef_pwm_deadtime.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ef_pwm_deadtime.sv
// ef_pwm_deadtime: complementary high/low gate-drive stage for one PWM channel.
// Inserts programmable dead time on both edges and holds a latched fault
// shutdown until it is explicitly released. h_act/l_act come straight from flops
// and are decoded from the *next* state, so they can never both be high.
module ef_pwm_deadtime #(
   parameter int DT_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            pwm_in,
   input  logic [DT_W-1:0] dt_rise,
   input  logic [DT_W-1:0] dt_fall,
   input  logic            pol_h,
   input  logic            pol_l,
   input  logic            fault,
   input  logic            fault_clr,
   output logic            pwm_h,
   output logic            pwm_l,
   output logic            fault_latched
);

   // State encoding; every state other than LOW/HIGH drives both sides inactive.
   localparam logic [2:0] ST_OFF    = 3'd0;
   localparam logic [2:0] ST_LOW    = 3'd1;
   localparam logic [2:0] ST_DEAD_R = 3'd2;
   localparam logic [2:0] ST_HIGH   = 3'd3;
   localparam logic [2:0] ST_DEAD_F = 3'd4;
   localparam logic [2:0] ST_FAULT  = 3'd5;

   localparam logic [DT_W-1:0] DT_ONE = DT_W'(1);

   logic [2:0]      state_q, state_d;
   logic [DT_W-1:0] cnt_q, cnt_d;
   logic            h_act_q, h_act_d;
   logic            l_act_q, l_act_d;
   logic            fault_q, fault_d;

   // Entry into the falling dead band, shared by start-up from OFF and by fault release.
   // With dt_fall=0 there is no dead band to count, so we go directly to the side
   // that pwm_in asks for instead of loading a wrapped (all-ones) count.
   logic [2:0]      fall_entry_state;
   logic [DT_W-1:0] fall_entry_cnt;

   // Compute the dead-band entry target from the current dt_fall and pwm_in.
   always_comb begin
      fall_entry_state = ST_DEAD_F;
      fall_entry_cnt   = dt_fall - DT_ONE;
      if (dt_fall == '0) begin
         fall_entry_cnt   = '0;
         fall_entry_state = pwm_in ? ST_HIGH : ST_LOW;
      end
   end

   // Next-state logic: fault first, then enable, then the dead-time sequencing.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;

      if (fault) begin
         state_d = ST_FAULT;
         cnt_d   = '0;
      end else if (state_q == ST_FAULT) begin
         // FAULT ignores en; only a clear pulse (with fault already low) leaves it.
         if (fault_clr) begin
            if (en) begin
               state_d = fall_entry_state;
               cnt_d   = fall_entry_cnt;
            end else begin
               state_d = ST_OFF;
               cnt_d   = '0;
            end
         end
      end else if (!en) begin
         state_d = ST_OFF;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_OFF: begin
               state_d = fall_entry_state;
               cnt_d   = fall_entry_cnt;
            end
            ST_LOW: begin
               if (pwm_in) begin
                  if (dt_rise == '0) begin
                     state_d = ST_HIGH;
                  end else begin
                     state_d = ST_DEAD_R;
                     cnt_d   = dt_rise - DT_ONE;
                  end
               end
            end
            ST_DEAD_R: begin
               // A pulse shorter than the dead time is dropped: only L was released.
               if (!pwm_in) begin
                  state_d = ST_LOW;
               end else if (cnt_q == '0) begin
                  state_d = ST_HIGH;
               end else begin
                  cnt_d = cnt_q - DT_ONE;
               end
            end
            ST_HIGH: begin
               if (!pwm_in) begin
                  if (dt_fall == '0) begin
                     state_d = ST_LOW;
                  end else begin
                     state_d = ST_DEAD_F;
                     cnt_d   = dt_fall - DT_ONE;
                  end
               end
            end
            ST_DEAD_F: begin
               if (pwm_in) begin
                  state_d = ST_HIGH;
               end else if (cnt_q == '0) begin
                  state_d = ST_LOW;
               end else begin
                  cnt_d = cnt_q - DT_ONE;
               end
            end
            default: begin
               // Unused encodings recover to the safe all-off state.
               state_d = ST_OFF;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Output decode from the next state so the drive bits are registered, not decoded.
   always_comb begin
      h_act_d = (state_d == ST_HIGH);
      l_act_d = (state_d == ST_LOW);
      fault_d = (state_d == ST_FAULT);
   end

   // State, counter and drive registers; reset forces both sides inactive immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_OFF;
         cnt_q   <= '0;
         h_act_q <= 1'b0;
         l_act_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         h_act_q <= h_act_d;
         l_act_q <= l_act_d;
         fault_q <= fault_d;
      end
   end

   // Pin polarity is the only logic between the flops and the pads.
   assign pwm_h         = h_act_q ^ pol_h;
   assign pwm_l         = l_act_q ^ pol_l;
   assign fault_latched = fault_q;

endmodule

// File: tb/tb_ef_pwm_deadtime.sv
// Directed bench for ef_pwm_deadtime: expected pin values are queued as each
// step is driven and popped/compared after the clock edge (or immediately for
// the asynchronous reset checks). A negedge monitor checks h_act & l_act == 0.
module tb_ef_pwm_deadtime;

   localparam int DT_W = 8;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            en = 1'b0;
   logic            pwm_in = 1'b0;
   logic [DT_W-1:0] dt_rise = '0;
   logic [DT_W-1:0] dt_fall = '0;
   logic            pol_h = 1'b0;
   logic            pol_l = 1'b0;
   logic            fault = 1'b0;
   logic            fault_clr = 1'b0;
   logic            pwm_h;
   logic            pwm_l;
   logic            fault_latched;

   typedef struct {
      string      tag;
      logic [2:0] exp;   // {pwm_h, pwm_l, fault_latched}
   } sb_item_t;

   sb_item_t sb_q[$];
   int n_pass  = 0;
   int n_total = 0;

   ef_pwm_deadtime #(.DT_W(DT_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .pwm_in        (pwm_in),
      .dt_rise       (dt_rise),
      .dt_fall       (dt_fall),
      .pol_h         (pol_h),
      .pol_l         (pol_l),
      .fault         (fault),
      .fault_clr     (fault_clr),
      .pwm_h         (pwm_h),
      .pwm_l         (pwm_l),
      .fault_latched (fault_latched)
   );

   always #5 clk = ~clk;

   // Never both sides active: undo the pin polarity and check every cycle.
   always @(negedge clk) begin
      if (!rst) begin
         n_total++;
         assert (((pwm_h ^ pol_h) & (pwm_l ^ pol_l)) === 1'b0) n_pass++;
         else $error("FAIL overlap: observed h_act=%b l_act=%b required not both 1",
                     pwm_h ^ pol_h, pwm_l ^ pol_l);
      end
   end

   task automatic push_exp(input logic h, input logic l, input logic f, input string tag);
      sb_item_t it;
      it.tag = tag;
      it.exp = {h, l, f};
      sb_q.push_back(it);
   endtask

   task automatic check_pop();
      sb_item_t   it;
      logic [2:0] obs;
      n_total++;
      if (sb_q.size() == 0) begin
         $error("FAIL scoreboard_empty: observed no entry required one entry");
      end else begin
         it  = sb_q.pop_front();
         obs = {pwm_h, pwm_l, fault_latched};
         assert (obs === it.exp) n_pass++;
         else $error("FAIL %s: observed h/l/flt=%b required %b", it.tag, obs, it.exp);
         $display("chk %-14s h/l/flt=%b exp=%b t=%0t", it.tag, obs, it.exp, $time);
      end
   endtask

   // One clock edge, then compare the pins against the queued expectation.
   task automatic cyc(input logic h, input logic l, input logic f, input string tag);
      push_exp(h, l, f, tag);
      @(posedge clk);
      #1;
      check_pop();
   endtask

   initial begin
      // ---- 1: reset, start-up through DEAD_F into LOW ----
      en      = 1'b1;
      dt_rise = 8'd3;
      dt_fall = 8'd2;
      pwm_in  = 1'b0;
      #2 rst = 1'b1;
      #1;
      push_exp(1'b0, 1'b0, 1'b0, "rst_async");
      check_pop();
      @(posedge clk);
      #1;
      push_exp(1'b0, 1'b0, 1'b0, "rst_hold");
      check_pop();
      rst = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, "t1_deadf0");
      cyc(1'b0, 1'b0, 1'b0, "t1_deadf1");
      for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, "t1_low");

      // ---- 2: rising edge with dt_rise=3, falling edge with dt_fall=2 ----
      pwm_in = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, "t2_l_drop");
      cyc(1'b0, 1'b0, 1'b0, "t2_deadr1");
      cyc(1'b0, 1'b0, 1'b0, "t2_deadr2");
      for (int i = 0; i < 17; i++) cyc(1'b1, 1'b0, 1'b0, "t2_high");
      pwm_in = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, "t2_h_drop");
      cyc(1'b0, 1'b0, 1'b0, "t2_deadf1");
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, "t2_low");

      // ---- 3: 2-cycle pulse shorter than dt_rise=5 is swallowed ----
      dt_rise = 8'd5;
      pwm_in  = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, "t3_pulse0");
      cyc(1'b0, 1'b0, 1'b0, "t3_pulse1");
      pwm_in = 1'b0;
      for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, "t3_abort");

      // ---- 4: zero dead time, outputs are 1-cycle-late complements ----
      dt_rise = 8'd0;
      dt_fall = 8'd0;
      for (int p = 0; p < 5; p++) begin
         pwm_in = (p % 2 == 0);
         for (int k = 0; k < 4; k++) cyc(pwm_in, ~pwm_in, 1'b0, "t4_dt0");
      end

      // ---- 5: fault while HIGH, ignored clear, then real release ----
      dt_rise = 8'd3;
      dt_fall = 8'd2;
      fault   = 1'b1;
      cyc(1'b0, 1'b0, 1'b1, "t5_fault");
      cyc(1'b0, 1'b0, 1'b1, "t5_fault_hold");
      fault_clr = 1'b1;
      cyc(1'b0, 1'b0, 1'b1, "t5_clr_ignored");
      fault_clr = 1'b0;
      fault     = 1'b0;
      pwm_in    = 1'b0;
      cyc(1'b0, 1'b0, 1'b1, "t5_latched");
      en = 1'b0;
      cyc(1'b0, 1'b0, 1'b1, "t5_en0_hold");
      en        = 1'b1;
      fault_clr = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, "t5_release");
      fault_clr = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, "t5_deadf");
      cyc(1'b0, 1'b1, 1'b0, "t5_low");

      // ---- 6: inverted pins, reset in DEAD_R and in HIGH ----
      en = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, "t6_off");
      pol_h = 1'b1;
      pol_l = 1'b1;
      #1;
      push_exp(1'b1, 1'b1, 1'b0, "t6_pol_idle");
      check_pop();
      en = 1'b1;
      cyc(1'b1, 1'b1, 1'b0, "t6_deadf0");
      cyc(1'b1, 1'b1, 1'b0, "t6_deadf1");
      cyc(1'b1, 1'b0, 1'b0, "t6_low_inv");
      pwm_in = 1'b1;
      cyc(1'b1, 1'b1, 1'b0, "t6_deadr0");
      cyc(1'b1, 1'b1, 1'b0, "t6_deadr1");
      #2 rst = 1'b1;
      #1;
      push_exp(1'b1, 1'b1, 1'b0, "t6_rst_deadr");
      check_pop();
      @(posedge clk);
      #1;
      rst = 1'b0;
      // From OFF: DEAD_F first, then pwm_in=1 aborts straight to HIGH.
      cyc(1'b1, 1'b1, 1'b0, "t6_after_rst");
      cyc(1'b0, 1'b1, 1'b0, "t6_high_inv");
      cyc(1'b0, 1'b1, 1'b0, "t6_high_hold");
      #2 rst = 1'b1;
      #1;
      push_exp(1'b1, 1'b1, 1'b0, "t6_rst_high");
      check_pop();
      @(posedge clk);
      #1;
      rst = 1'b0;
      en  = 1'b0;
      cyc(1'b1, 1'b1, 1'b0, "t6_off_end");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
